body_line_rasterizer: RTL and testbench

//  Consumer end of the body-model endpoint table: steps lineCount through every line, captures (x1,y1,x2,y2),

---
 rtl/body_line_rasterizer.sv | 162 ++++++++++++++++
 tb/tb_body_line_rasterizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/body_line_rasterizer.sv
// Body-model line rasterizer: walks the endpoint LUT line by line and traces
// each segment with integer Bresenham, emitting one pixel write per step over
// a valid/ready handshake. Off-screen points are traced but not emitted.
module body_line_rasterizer #(
    parameter int unsigned NUM_LINES = 48,
    parameter int unsigned H_ACT     = 640,
    parameter int unsigned V_ACT     = 480
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    output logic [5:0] oLineCount,
    input  logic [9:0] iX1,
    input  logic [9:0] iX2,
    input  logic [8:0] iY1,
    input  logic [8:0] iY2,
    output logic [9:0] oPixX,
    output logic [8:0] oPixY,
    output logic       oPixValid,
    input  logic       iPixReady,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic signed [11:0] H_LIM     = 12'(H_ACT);
    localparam logic signed [11:0] V_LIM     = 12'(V_ACT);
    localparam logic [5:0]         LAST_LINE = 6'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SETUP,
        S_DRAW,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic [5:0]         line_count;
    logic signed [11:0] x1_r, y1_r, x2_r, y2_r;
    logic signed [11:0] cur_x, cur_y;
    logic signed [11:0] dx, dy, sx, sy, err;

    logic               on_screen;
    logic               step;
    logic               at_end;
    logic               last_line;
    logic signed [11:0] abs_x, abs_y;
    logic signed [12:0] e2;
    logic signed [11:0] err_nx, x_nx, y_nx;

    // Per-cycle Bresenham arithmetic and step qualification
    always_comb begin
        on_screen = (cur_x < H_LIM) && (cur_y < V_LIM);
        // Off-screen points advance without waiting on the writer
        step      = (state == S_DRAW) && (!on_screen || iPixReady);
        at_end    = (cur_x == x2_r) && (cur_y == y2_r);
        last_line = (line_count == LAST_LINE);
        abs_x     = (x2_r >= x1_r) ? (x2_r - x1_r) : (x1_r - x2_r);
        abs_y     = (y2_r >= y1_r) ? (y2_r - y1_r) : (y1_r - y2_r);
        e2        = {err, 1'b0};
        err_nx    = err;
        x_nx      = cur_x;
        y_nx      = cur_y;
        if (e2 >= $signed({dy[11], dy})) begin
            err_nx = err_nx + dy;
            x_nx   = cur_x + sx;
        end
        if (e2 <= $signed({dx[11], dx})) begin
            err_nx = err_nx + dx;
            y_nx   = cur_y + sy;
        end
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (iStart) state_next = S_ADDR;
            S_ADDR:  state_next = S_SETUP;
            S_SETUP: state_next = S_DRAW;
            S_DRAW: begin
                if (step && at_end) begin
                    state_next = last_line ? S_FIN : S_ADDR;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        oLineCount = line_count;
        oPixX      = cur_x[9:0];
        oPixY      = cur_y[8:0];
        oPixValid  = (state == S_DRAW) && on_screen;
        oBusy      = (state != S_IDLE);
        oDone      = (state == S_FIN);
    end

    // Line index, endpoint capture, setup and stepping datapath
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            line_count <= '0;
            x1_r       <= '0;
            y1_r       <= '0;
            x2_r       <= '0;
            y2_r       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            sx         <= '0;
            sy         <= '0;
            err        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iStart) line_count <= '0;
                end
                S_ADDR: begin
                    x1_r <= {2'b00, iX1};
                    y1_r <= {3'b000, iY1};
                    x2_r <= {2'b00, iX2};
                    y2_r <= {3'b000, iY2};
                end
                S_SETUP: begin
                    dx    <= abs_x;
                    dy    <= -abs_y;
                    sx    <= (x1_r < x2_r) ? 12'sd1 : -12'sd1;
                    sy    <= (y1_r < y2_r) ? 12'sd1 : -12'sd1;
                    err   <= abs_x - abs_y;
                    cur_x <= x1_r;
                    cur_y <= y1_r;
                end
                S_DRAW: begin
                    if (step) begin
                        if (at_end) begin
                            if (!last_line) line_count <= line_count + 6'd1;
                        end else begin
                            err   <= err_nx;
                            cur_x <= x_nx;
                            cur_y <= y_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_body_line_rasterizer.sv
// Scoreboard bench for body_line_rasterizer with a small stub endpoint LUT.
module tb_body_line_rasterizer;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       iStart;
    logic [5:0] oLineCount;
    logic [9:0] iX1, iX2;
    logic [8:0] iY1, iY2;
    logic [9:0] oPixX;
    logic [8:0] oPixY;
    logic       oPixValid;
    logic       iPixReady;
    logic       oBusy;
    logic       oDone;

    int tbl;
    bit bp_armed;
    int done_seen;
    int chk_cnt;
    int pass_cnt;

    typedef struct {
        int lc;
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];

    bit         hold_pending;
    logic [9:0] hold_x;
    logic [8:0] hold_y;

    always #5 iCLK = ~iCLK;

    body_line_rasterizer #(
        .NUM_LINES(3),
        .H_ACT(640),
        .V_ACT(480)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .iStart(iStart),
        .oLineCount(oLineCount),
        .iX1(iX1),
        .iX2(iX2),
        .iY1(iY1),
        .iY2(iY2),
        .oPixX(oPixX),
        .oPixY(oPixY),
        .oPixValid(oPixValid),
        .iPixReady(iPixReady),
        .oBusy(oBusy),
        .oDone(oDone)
    );

    // Stub endpoint LUT: table 0 = straight/steep-reverse/shallow lines,
    // table 1 = x-clipped line, single point, y-clipped vertical line
    always_comb begin
        iX1 = '0; iY1 = '0; iX2 = '0; iY2 = '0;
        if (tbl == 0) begin
            case (oLineCount)
                6'd0: begin iX1 = 10; iY1 = 5; iX2 = 13; iY2 = 5; end
                6'd1: begin iX1 = 2;  iY1 = 5; iX2 = 0;  iY2 = 0; end
                6'd2: begin iX1 = 0;  iY1 = 0; iX2 = 7;  iY2 = 3; end
                default: ;
            endcase
        end else begin
            case (oLineCount)
                6'd0: begin iX1 = 638; iY1 = 10;  iX2 = 642; iY2 = 10;  end
                6'd1: begin iX1 = 5;   iY1 = 5;   iX2 = 5;   iY2 = 5;   end
                6'd2: begin iX1 = 3;   iY1 = 478; iX2 = 3;   iY2 = 482; end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int expv);
        chk_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic push(input int lc, input int x, input int y);
        pix_t p;
        p.lc = lc; p.x = x; p.y = y;
        exp_q.push_back(p);
    endtask

    task automatic push_table0();
        push(0, 10, 5); push(0, 11, 5); push(0, 12, 5); push(0, 13, 5);
        push(1, 2, 5); push(1, 2, 4); push(1, 1, 3);
        push(1, 1, 2); push(1, 0, 1); push(1, 0, 0);
        push(2, 0, 0); push(2, 1, 0); push(2, 2, 1); push(2, 3, 1);
        push(2, 4, 2); push(2, 5, 2); push(2, 6, 3); push(2, 7, 3);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_linecount"}, int'(oLineCount), 0);
        check({tag, "_pixx"}, int'(oPixX), 0);
        check({tag, "_pixy"}, int'(oPixY), 0);
        check({tag, "_valid"}, int'(oPixValid), 0);
        check({tag, "_busy"}, int'(oBusy), 0);
        check({tag, "_done"}, int'(oDone), 0);
    endtask

    task automatic pulse_start();
        @(posedge iCLK);
        #1 iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
    endtask

    task automatic run_frame(input int t, input bit restart_pulse, input int budget);
        int n;
        tbl       = t;
        done_seen = 0;
        pulse_start();
        check("busy_after_start", int'(oBusy), 1);
        if (restart_pulse) begin
            repeat (4) @(posedge iCLK);
            #1 iStart = 1'b1;
            @(posedge iCLK);
            #1 iStart = 1'b0;
        end
        n = 0;
        while (done_seen == 0 && n < budget) begin
            @(posedge iCLK);
            n++;
        end
        if (done_seen == 0) check("done_timeout", 0, 1);
        repeat (3) @(posedge iCLK);
        #1;
        check("done_count", done_seen, 1);
        check("busy_after_done", int'(oBusy), 0);
        check("valid_after_done", int'(oPixValid), 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Scoreboard monitor: pops an expected pixel on every accepted handshake
    // and checks that a stalled pixel is held unchanged
    always @(negedge iCLK) begin
        pix_t e;
        if (iRST_N) begin
            if (hold_pending) begin
                check("hold_x", int'(oPixX), int'(hold_x));
                check("hold_y", int'(oPixY), int'(hold_y));
                check("hold_valid", int'(oPixValid), 1);
            end
            hold_pending = oPixValid && !iPixReady;
            hold_x       = oPixX;
            hold_y       = oPixY;
            if (oPixValid && iPixReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", (int'(oLineCount) << 20) | (int'(oPixX) << 10) | int'(oPixY), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_linecount", int'(oLineCount), e.lc);
                    check("pix_x", int'(oPixX), e.x);
                    check("pix_y", int'(oPixY), e.y);
                end
            end
            if (oDone) done_seen++;
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Writer model: always ready, except a 5-cycle stall on the second pixel
    // of line 2 in table 0 when armed
    initial begin
        iPixReady = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            if (bp_armed && tbl == 0 && oLineCount == 6'd2 && oPixValid && oPixX == 10'd1 && oPixY == 9'd0) begin
                bp_armed  = 1'b0;
                iPixReady = 1'b0;
                repeat (5) @(posedge iCLK);
                #1 iPixReady = 1'b1;
            end
        end
    end

    initial begin
        iRST_N       = 1'b0;
        iStart       = 1'b0;
        tbl          = 0;
        bp_armed     = 1'b0;
        done_seen    = 0;
        chk_cnt      = 0;
        pass_cnt     = 0;
        hold_pending = 1'b0;

        repeat (3) @(posedge iCLK);
        #1 check_zero_outputs("reset");
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Horizontal, steep-reverse and shallow lines with a writer stall and
        // a stray start pulse mid-draw
        push_table0();
        bp_armed = 1'b1;
        run_frame(0, 1'b1, 500);
        check("stall_happened", int'(bp_armed), 0);
        check("linecount_holds_last", int'(oLineCount), 2);

        // Clipping in x and y, zero-length segment
        push(0, 638, 10); push(0, 639, 10);
        push(1, 5, 5);
        push(2, 3, 478); push(2, 3, 479);
        run_frame(1, 1'b0, 500);
        check("linecount_holds_last_b", int'(oLineCount), 2);

        // Reset mid-line aborts with no done
        tbl = 0;
        push_table0();
        done_seen = 0;
        pulse_start();
        repeat (6) @(posedge iCLK);
        #3 iRST_N = 1'b0;
        #1 check_zero_outputs("abort");
        exp_q.delete();
        repeat (5) @(posedge iCLK);
        check("abort_no_done", done_seen, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Restart after abort draws the full frame again
        push_table0();
        run_frame(0, 1'b0, 500);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
